stream_demux: RTL
=================

Name: stream_demux

Overview:
- Sequential 1-to-N demultiplexer for a valid/ready stream. Each input beat goes to the output selected by the in_sel field sent with that beat.
- One registered slot gives a fixed 1-cycle latency. The slot passes data through every cycle, so throughput is 1 beat/cycle.
- Sits after any producer that tags beats with a destination. It is the inverse of the N-to-1 stream mux used in the combinational/stream exercises.

Parameters:
- N, 4, number of output ports; legal range 2..16.
- W, 8, data width in bits.
- SW, $clog2(N), select width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  W  input payload.
- in_sel  input  SW  destination index for the beat.
- out_valid  output  N  one-hot valid; bit k means output k holds a beat.
- out_ready  input  N  per-output ready from the consumers.
- out_data  output  W  shared payload bus; meaningful only where out_valid is set.

Behaviour:
- Reset, sampled on clk while rst=1:
  - slot empty, out_valid=0, out_data=0, dest=0.
  - Any beat held at reset is discarded; no partial state survives.
- Acceptance:
  - in_ready = !slot_full || out_ready[dest].
  - An input handshake happens when in_valid && in_ready.
- Output handshake happens when slot_full && out_ready[dest].
- Latency: a beat accepted at edge t appears on out_valid/out_data from edge t+1.
- Simultaneous events: an output handshake and an input handshake on the same edge:
  - the slot reloads with the new beat, dest=in_sel;
  - no bubble, 1 beat/cycle sustained.
- Hold rule:
  - while out_valid[dest]=1 && out_ready[dest]=0, out_data and out_valid are stable;
  - in_ready=0 in that case.
- Head-of-line blocking is intended: a stalled destination blocks beats for the other destinations.
- Readiness: out_ready bits for non-selected outputs are ignored.
- No combinational path from in_* to out_*. The only combinational path is out_ready → in_ready.
- State: EMPTY/FULL, encoded as slot_full.
  - EMPTY→FULL on input handshake.
  - FULL→EMPTY on output handshake without input handshake.
  - FULL→FULL on stall, or on output and input handshake together.
- Out-of-range in_sel (in_sel ≥ N, possible only when N is not a power of two): handling depends on the optional feature.
- out_valid is at most one-hot at every cycle; this is an assertion target.

Optional Feature:
- Macro: STREAM_DEMUX_SEL_CHECK_EN.
- Defined:
  - An out-of-range in_sel beat is accepted (in_ready=1 unless the slot is blocked) and dropped; the slot is not loaded.
  - Extra output port sel_err (1 bit) pulses high for exactly one cycle, the cycle after the drop. Reset value 0.
- Undefined:
  - No sel_err port.
  - An out-of-range in_sel is routed to output 0; the upper select bits are ignored.

Decomposition:
- Package stream_demux_pkg holds:
  - MAX_N constant (16);
  - function sel_in_range(sel, n);
  - typedef for the slot state.
- Sub-module stream_reg_slice (one-entry valid/ready register, W+SW bits wide) holds data and dest.
- stream_demux instantiates it and adds the one-hot decode and the out_ready select.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, out_data=0, no beat leaks after release.
- Basic routing: N=4, W=8, beat 0xA5 with sel=2, all out_ready=1 → next cycle out_valid=4'b0100, out_data=0xA5, in_ready stays 1.
- Back-to-back beats: beats 0x01..0x08 with sel cycling 0..3, all ready → 8 beats in 8 consecutive cycles, each on the correct one-hot output, in order.
- Stall: beat 0x3C with sel=1, out_ready[1]=0 for 3 cycles while out_ready[0]=1 → in_ready=0, out_data=0x3C stable for 3 cycles; beat released on the cycle out_ready[1] rises.
- Reset mid-stall: slot holds 0x77 with out_ready=0, then rst pulses 1 cycle → out_valid=0, the held beat is never delivered.
- N=3, sel=3:
  - with STREAM_DEMUX_SEL_CHECK_EN → beat dropped, sel_err=1 for one cycle, out_valid=0;
  - without the macro → delivered with out_valid=3'b001.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Latency: none (declarations only). Backpressure: not applicable.
// Contents: MAX_N bound, slot state enum, select range check.
package stream_demux_pkg;

  // Largest supported output count, and the select width that covers it.
  localparam int unsigned MAX_N  = 16;
  localparam int unsigned MAX_SW = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // True when sel addresses an existing output (sel < n).
  function automatic logic sel_in_range(input logic [MAX_SW-1:0] sel,
                                        input int unsigned n);
    return 32'(sel) < n;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice holding a DW-bit word.
// Latency: 1 cycle from input handshake to out_valid. Throughput 1 beat/cycle.
// Backpressure: in_ready = empty || out_ready, so a draining slot reloads on the same edge.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream.
module stream_reg_slice
  import stream_demux_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          in_hs;
  logic          out_hs;

  assign in_ready = (state_q == SLOT_EMPTY) || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = (state_q == SLOT_FULL) && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (in_hs) begin
      // Covers both EMPTY->FULL and the simultaneous drain+reload case.
      state_d = SLOT_FULL;
      data_d  = in_data;
    end else if (out_hs) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N valid/ready demultiplexer: each beat is steered to output in_sel.
// Latency: 1 cycle, 1 beat/cycle sustained. Backpressure: only the selected
// output's ready matters; a stalled destination blocks all following beats.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_sel;
//        out_valid (one-hot, N), out_ready (N), out_data (shared bus).
// Option STREAM_DEMUX_SEL_CHECK_EN: out-of-range in_sel beats are accepted and
//        dropped, and sel_err pulses for one cycle afterwards. Without it such
//        beats go to output 0.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_sel,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [W-1:0]  out_data
`ifdef STREAM_DEMUX_SEL_CHECK_EN
  ,
  output logic          sel_err
`endif
);

  logic             sel_ok;
  logic [SW-1:0]    sel_eff;
  logic             slice_in_valid;
  logic             slot_vld;
  logic             slot_rdy;
  logic [W+SW-1:0]  slot_dat;
  logic [SW-1:0]    dest;

  assign sel_ok = sel_in_range(MAX_SW'(in_sel), N);

  // Stored destination is always a legal index, so out_ready[dest] never
  // reads past the port and the decode below stays one-hot.
  assign sel_eff = sel_ok ? in_sel : '0;

`ifdef STREAM_DEMUX_SEL_CHECK_EN
  // A bad beat still handshakes with the producer but never enters the slot.
  assign slice_in_valid = in_valid && sel_ok;
`else
  assign slice_in_valid = in_valid;
`endif

  stream_reg_slice #(
    .DW (W + SW)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (slice_in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_eff, in_data}),
    .out_valid (slot_vld),
    .out_ready (slot_rdy),
    .out_data  (slot_dat)
  );

  assign dest     = slot_dat[W+SW-1:W];
  assign out_data = slot_dat[W-1:0];
  assign slot_rdy = out_ready[dest];

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (slot_vld && (dest == SW'(k))) begin
        out_valid[k] = 1'b1;
      end
    end
  end

`ifdef STREAM_DEMUX_SEL_CHECK_EN
  logic sel_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= in_valid && in_ready && !sel_ok;
    end
  end

  assign sel_err = sel_err_q;
`endif

  a_out_valid_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid));

endmodule
